fetch_miss_ctrl: RTL
====================

// Module: fetch_miss_ctrl
// PURPOSE
//  Sequences the IF stage on an L1I miss: translates the miss VA via the L2 TLB, fetches the
//  line from L2 cache, returns it as a one-cycle fill to the L1I. Holds IF stalled meanwhile.
//  Sits beside fetch, between it and the shared L2 TLB / L2 cache request ports.
// PARAMETERS
//  VADDR_W   64    virtual address width
//  PADDR_W   56    physical address width; PPN width = PADDR_W-12 (4 KiB pages)
//  LINE_W    512   L1I line width in bits; line offset = log2(LINE_W/8)
//  TIMEOUT   1024  max cycles in any *_WAIT/DRAIN state before abandon (>=2)
// PORTS
//  i_clk           in   1         clock
//  i_rst_n         in   1         reset, asynchronous, active-low
//  i_flush         in   1         pipeline flush; abort current miss
//  i_miss          in   1         L1I miss from IF this cycle
//  i_miss_vaddr    in   VADDR_W   VA of missing fetch
//  i_paging_en     in   1         from program state; 0 => PA = VA[PADDR_W-1:0], no TLB
//  o_stall         out  1         stall IF
//  o_l2tlb_req     out  1         TLB lookup request
//  o_l2tlb_vaddr   out  VADDR_W   lookup VA
//  i_l2tlb_ack     in   1         request accepted
//  i_l2tlb_resp    in   1         lookup result valid
//  i_l2tlb_ppn     in   PADDR_W-12 result PPN
//  i_l2tlb_fault   in   1         translation fault
//  o_l2cache_req   out  1         line read request
//  o_l2cache_paddr out  PADDR_W   line-aligned PA
//  i_l2cache_ack   in   1         request accepted
//  i_l2cache_resp  in   1         line data valid
//  i_l2cache_data  in   LINE_W    line data
//  o_fill_valid    out  1         fill strobe to L1I
//  o_fill_vaddr    out  VADDR_W   line-aligned VA of fill
//  o_fill_paddr    out  PADDR_W   line-aligned PA of fill
//  o_fill_data     out  LINE_W    line data (0 on exception)
//  o_fill_except   out  2         0 none, 1 page fault, 2 bus timeout
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all o_* 0, latched VA/PA 0.
//  States: IDLE, TLB_REQ, TLB_WAIT, L2_REQ, L2_WAIT, FILL, DRAIN.
//  IDLE: i_miss & ~i_flush -> latch VA; next TLB_REQ (paging) or L2_REQ (PA = VA, offset zeroed).
//  o_stall = (state!=IDLE) | (state==IDLE & i_miss & ~i_flush); combinational, same-cycle hold.
//  REQ states: req=1, address stable until ack; req&ack in a cycle = accepted -> matching WAIT.
//  WAIT states: resp honoured from the cycle after acceptance; resp outside WAIT/DRAIN ignored.
//  TLB_WAIT resp: fault -> FILL with except=1 (no L2 access); else PA={ppn,VA[11:0]} aligned -> L2_REQ.
//  L2_WAIT resp: latch data -> FILL except=0.
//  FILL: o_fill_valid=1 for exactly one cycle (registered outputs), then IDLE; o_stall=1 in FILL.
//  Timeout: counter cleared on WAIT/DRAIN entry, +1 per cycle; reaching TIMEOUT-1 with no resp
//   -> FILL except=2, data 0 (from DRAIN: -> IDLE). Counter saturates, never wraps.
//  Flush in *_REQ: drop req same cycle (combinational gate), IDLE next cycle.
//  Flush in *_WAIT: DRAIN; wait for the outstanding resp, discard it, -> IDLE. o_stall stays 1.
//  Flush with resp in same WAIT cycle: response consumed and discarded, -> IDLE.
//  Flush in FILL: o_fill_valid gated 0 that cycle; -> IDLE.
//  New i_miss in non-IDLE states ignored (IF already stalled). Misses are never queued.
//  Async reset mid-transaction: immediate IDLE; in-flight responses later ignored.
// TESTING
//  Paging off, miss VA 0x1234, ack cyc+1, resp cyc+3 -> paddr 0x1200, one fill, stall drops after.
//  Paging on, ppn 0x8_0000, VA 0xABC -> o_l2cache_paddr 0x8000_0A80 (LINE_W=512), except 0.
//  TLB fault on resp -> no o_l2cache_req, fill except=1, data 0.
//  Ack withheld 5 cycles -> req/addr stable all 5; single transaction only.
//  Flush in L2_WAIT, resp 3 cycles later -> no fill, IDLE after resp, stall high until then.
//  TIMEOUT=8, no resp -> fill except=2 exactly 8 cycles after entry; late resp ignored.

Source files
------------

// File: rtl/fetch_miss_ctrl.sv
// L1I miss sequencer: translates the miss VA through the L2 TLB, reads the line from the
// L2 cache, and hands it to the L1I as a single-cycle fill while holding IF stalled.
module fetch_miss_ctrl #(
  parameter int VADDR_W = 64,
  parameter int PADDR_W = 56,
  parameter int LINE_W  = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_miss,
  input  logic [VADDR_W-1:0] i_miss_vaddr,
  input  logic               i_paging_en,
  output logic               o_stall,
  output logic               o_l2tlb_req,
  output logic [VADDR_W-1:0] o_l2tlb_vaddr,
  input  logic               i_l2tlb_ack,
  input  logic               i_l2tlb_resp,
  input  logic [PADDR_W-13:0] i_l2tlb_ppn,
  input  logic               i_l2tlb_fault,
  output logic               o_l2cache_req,
  output logic [PADDR_W-1:0] o_l2cache_paddr,
  input  logic               i_l2cache_ack,
  input  logic               i_l2cache_resp,
  input  logic [LINE_W-1:0]  i_l2cache_data,
  output logic               o_fill_valid,
  output logic [VADDR_W-1:0] o_fill_vaddr,
  output logic [PADDR_W-1:0] o_fill_paddr,
  output logic [LINE_W-1:0]  o_fill_data,
  output logic [1:0]         o_fill_except
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, TLB_REQ, TLB_WAIT, L2_REQ, L2_WAIT, FILL, DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [VADDR_W-1:0]  va_q, va_d;
  logic [PADDR_W-1:0]  pa_q, pa_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic [1:0]          except_q, except_d;
  logic                drain_l2_q, drain_l2_d;
  logic                timeout;
  logic                drain_resp;

  function automatic logic [PADDR_W-1:0] align_pa(input logic [PADDR_W-1:0] pa);
    return {pa[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  function automatic logic counting(input state_t s);
    return (s == TLB_WAIT) || (s == L2_WAIT) || (s == DRAIN);
  endfunction

  assign timeout    = (cnt_q == CNT_LAST);
  assign drain_resp = drain_l2_q ? i_l2cache_resp : i_l2tlb_resp;

  always_comb begin
    state_d    = state_q;
    va_d       = va_q;
    pa_d       = pa_q;
    data_d     = data_q;
    except_d   = except_q;
    drain_l2_d = drain_l2_q;
    case (state_q)
      IDLE: begin
        if (i_miss && !i_flush) begin
          va_d = i_miss_vaddr;
          if (i_paging_en) begin
            state_d = TLB_REQ;
          end else begin
            pa_d    = align_pa(i_miss_vaddr[PADDR_W-1:0]);
            state_d = L2_REQ;
          end
        end
      end
      TLB_REQ: begin
        if (i_flush)          state_d = IDLE;
        else if (i_l2tlb_ack) state_d = TLB_WAIT;
      end
      TLB_WAIT: begin
        if (i_l2tlb_resp) begin
          if (i_flush) begin
            state_d = IDLE;
          end else if (i_l2tlb_fault) begin
            except_d = 2'd1;
            data_d   = '0;
            state_d  = FILL;
          end else begin
            pa_d    = align_pa({i_l2tlb_ppn, va_q[11:0]});
            state_d = L2_REQ;
          end
        end else if (i_flush) begin
          drain_l2_d = 1'b0;
          state_d    = DRAIN;
        end else if (timeout) begin
          except_d = 2'd2;
          data_d   = '0;
          state_d  = FILL;
        end
      end
      L2_REQ: begin
        if (i_flush)            state_d = IDLE;
        else if (i_l2cache_ack) state_d = L2_WAIT;
      end
      L2_WAIT: begin
        if (i_l2cache_resp) begin
          if (i_flush) begin
            state_d = IDLE;
          end else begin
            data_d   = i_l2cache_data;
            except_d = 2'd0;
            state_d  = FILL;
          end
        end else if (i_flush) begin
          drain_l2_d = 1'b1;
          state_d    = DRAIN;
        end else if (timeout) begin
          except_d = 2'd2;
          data_d   = '0;
          state_d  = FILL;
        end
      end
      FILL:    state_d = IDLE;
      // The outstanding response (or a timeout) is the only way out; flushes change nothing here.
      DRAIN:   if (drain_resp || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      va_q       <= '0;
      pa_q       <= '0;
      data_q     <= '0;
      except_q   <= '0;
      drain_l2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      va_q       <= va_d;
      pa_q       <= pa_d;
      data_q     <= data_d;
      except_q   <= except_d;
      drain_l2_q <= drain_l2_d;
      // Counter restarts on entry to any waiting state and saturates at the timeout value.
      if (counting(state_d) && (state_d != state_q)) cnt_q <= '0;
      else if (counting(state_q) && !timeout)         cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_stall         = (state_q != IDLE) || (i_miss && !i_flush);
  assign o_l2tlb_req     = (state_q == TLB_REQ) && !i_flush;
  assign o_l2tlb_vaddr   = va_q;
  assign o_l2cache_req   = (state_q == L2_REQ) && !i_flush;
  assign o_l2cache_paddr = pa_q;
  assign o_fill_valid    = (state_q == FILL) && !i_flush;
  assign o_fill_vaddr    = {va_q[VADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign o_fill_paddr    = pa_q;
  assign o_fill_data     = data_q;
  assign o_fill_except   = except_q;

endmodule
